// File: rtl/trace_pkg.sv
// Shared definitions for the trace checker scheduler: FSM states, framing
// characters and checker format codes.
package trace_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StDrop,
        StClear,
        StPlay,
        StSample
    } state_e;

    localparam logic [7:0] CHAR_CARET = 8'h5e;
    localparam logic [7:0] CHAR_HASH  = 8'h23;
    localparam logic [7:0] CHAR_NUL   = 8'h00;

    localparam logic [1:0] FMT_BAD = 2'b00;
    localparam logic [1:0] FMT_REG = 2'b01;
    localparam logic [1:0] FMT_MEM = 2'b10;

endpackage

// File: rtl/trace_record_buffer.sv
// Record storage: synchronous write, combinational read, one byte per port.
module trace_record_buffer #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_check_scheduler.sv
// Shares one trace-format checker between two byte sources: captures a whole
// record, clears the checker, replays the record gap-free and reports the verdict.
module trace_check_scheduler
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] src_valid,
    input  logic [7:0] src_char0,
    input  logic [7:0] src_char1,
    output logic [1:0] src_ready,
    output logic       chk_reset,
    output logic [7:0] chk_char,
    input  logic [1:0] chk_format_type,
    output logic       res_valid,
    output logic       res_src,
    output logic [1:0] res_type,
    output logic       res_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_e        state_q, state_d;
    logic          grant_q, last_q;
    logic [CW-1:0] cnt_q, rd_q, len_q;

    logic       sel_valid;
    logic [7:0] sel_char;
    logic [7:0] rd_data;
    logic       is_hash, full, wr_en, ovf_done, idle_pick;

    assign sel_valid = src_valid[grant_q];
    assign sel_char  = grant_q ? src_char1 : src_char0;
    assign is_hash   = (sel_char == CHAR_HASH);
    assign full      = (cnt_q == FULL_CNT);
    assign wr_en     = (state_q == StCapture) && sel_valid && !full;
    // Overflowed record finishes either on a '#' in DROP or a '#' landing exactly at full.
    assign ovf_done  = sel_valid && is_hash &&
                       ((state_q == StDrop) || ((state_q == StCapture) && full));
    assign idle_pick = (&src_valid) ? ~last_q : src_valid[1];

    trace_record_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(cnt_q[AW-1:0]),
        .wr_data(sel_char),
        .rd_addr(rd_q[AW-1:0]),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|src_valid) state_d = StCapture;
            end
            StCapture: begin
                if (sel_valid) begin
                    if (full) begin
                        state_d = is_hash ? StIdle : StDrop;
                    end else if (is_hash) begin
                        state_d = StClear;
                    end
                end
            end
            StDrop: begin
                if (sel_valid && is_hash) state_d = StIdle;
            end
            StClear:  state_d = StPlay;
            StPlay: begin
                if (rd_q == len_q - 1'b1) state_d = StSample;
            end
            StSample: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        src_ready = 2'b00;
        chk_char  = CHAR_NUL;
        chk_reset = reset;
        unique case (state_q)
            StCapture, StDrop: src_ready[grant_q] = 1'b1;
            StClear:           chk_reset = 1'b1;
            StPlay:            chk_char = rd_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            rd_q         <= '0;
            len_q        <= '0;
            res_valid    <= 1'b0;
            res_src      <= 1'b0;
            res_type     <= FMT_BAD;
            res_overflow <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|src_valid) begin
                        grant_q <= idle_pick;
                        cnt_q   <= '0;
                    end
                end
                StCapture: begin
                    if (wr_en) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (is_hash) len_q <= cnt_q + 1'b1;
                    end
                end
                StClear: rd_q <= '0;
                StPlay:  rd_q <= rd_q + 1'b1;
                StSample: begin
                    res_valid    <= 1'b1;
                    res_src      <= grant_q;
                    res_type     <= chk_format_type;
                    res_overflow <= 1'b0;
                    last_q       <= grant_q;
                end
                default: ;
            endcase
            if (ovf_done) begin
                res_valid    <= 1'b1;
                res_src      <= grant_q;
                res_type     <= FMT_BAD;
                res_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/trace_check_scheduler.md
# trace_check_scheduler

Shares one `cpu_checker` trace-format checker between two character sources (e.g. two simulated CPU trace streams). Arbitrates at whole-record granularity and captures each record (`^` … `#`) into a local buffer. Then clears the checker and replays the record into it back-to-back, because the checker has no stall input. Reports the checker verdict, tagged with the source, as a one-cycle result pulse.

## Interface
- `DEPTH`, default 64: record buffer capacity in bytes (power of two, ≥ 16).
- `clk`  in  1: the only clock.
- `reset`  in  1: asynchronous, active-high.
- `src_valid`  in  2: per-source byte valid.
- `src_char0`  in  8: source 0 byte (ASCII).
- `src_char1`  in  8: source 1 byte (ASCII).
- `src_ready`  out  2: per-source ready; a byte transfers when valid && ready.
- `chk_reset`  out  1: drives the checker's synchronous `reset`.
- `chk_char`  out  8: drives the checker's `char`.
- `chk_format_type`  in  2: the checker's `format_type` (00 invalid, 01 register record, 10 memory record).
- `res_valid`  out  1: one-cycle result pulse.
- `res_src`  out  1: source of the reported record.
- `res_type`  out  2: verdict; 00 on overflow.
- `res_overflow`  out  1: record exceeded `DEPTH`.

## Operation
- **States:** IDLE, CAPTURE, DROP, CLEAR, PLAY, SAMPLE.
- **IDLE:** if any `src_valid` bit is set, grant it. If both are set, grant the source not granted last (round-robin). `last` resets to 1, so source 0 wins first. Go to CAPTURE. No byte is accepted in IDLE.
- **CAPTURE:** `src_ready[grant]`=1 and the other ready bit is 0. Each accepted byte is written to buffer[cnt] and cnt increments.
  - If the accepted byte is `#` and cnt < DEPTH: store it, then go to CLEAR with len = cnt+1.
  - If a byte is accepted while cnt == DEPTH (`#` included): go to DROP. If that byte was `#`, go to the overflow report directly.
- **DROP:** ready is held at 1 and bytes are discarded until `#` is accepted. Then issue the result `res_type`=00, `res_overflow`=1 and return to IDLE. There is no playout.
- **CLEAR:** one cycle with `chk_reset`=1 and `chk_char`=8'h00.
- **PLAY:** `chk_char` = buffer[rd] for rd = 0 … len-1, one byte per cycle with no gaps. After rd = len-1, go to SAMPLE.
- **SAMPLE:** latch `chk_format_type` into `res_type`, and `res_src` = grant. Set `last` = grant. Go to IDLE.
- **Result pulse:** `res_valid` is registered and pulses for exactly the cycle after SAMPLE or DROP completion. Outside PLAY, `chk_char` is 8'h00.
- **Record framing:** bytes before `^` are captured verbatim. Framing errors are for the checker to judge.
- The grant is never changed mid-record. The other source waits with ready=0.

## Timing
- **Reset values:** `src_ready`=0, `chk_reset`=1 (`chk_reset` = `reset` | CLEAR), `chk_char`=0, `res_valid`=0, `res_src`=0, `res_type`=00, `res_overflow`=0. State = IDLE, `last`=1, cnt=rd=0.
- **Reset mid-operation:** the buffer contents are abandoned and no result is emitted for the interrupted record.
- **Latency** for an L-byte record whose valid is continuous: 1 (IDLE) + L (CAPTURE) + 1 (CLEAR) + L (PLAY) + 1 (SAMPLE). `res_valid` rises in the following cycle.
- **Checker timing:** the checker updates on the edge that ends the `#` play cycle. Its `format_type` is valid during SAMPLE.
- **Source stalls:** `src_valid` gaps in CAPTURE stall capture only; they never reach the checker.
- **Counter widths:** cnt and rd are clog2(DEPTH)+1 bits wide, so no wrap occurs.

## Structure
- **Shared package `trace_pkg`:**
  - state encoding;
  - ASCII constants `^`, `#`, 8'h00;
  - format codes FMT_BAD = 00, FMT_REG = 01, FMT_MEM = 10.
- **Sub-module `trace_record_buffer`:** DEPTH×8 single-port-write / single-port-read storage with synchronous write and combinational read.
- The `cpu_checker` instance lives in the parent, wired to `chk_*`.

## Test plan
- Source 0 sends `^10@00003000:$ 1<=00000001#` → `chk_char` replays it contiguously after one `chk_reset` cycle; `res_valid`=1, `res_src`=0, `res_type`=01, `res_overflow`=0.
- Source 1 sends `^5@00003004:*00000010<=0000abcd#` → `res_src`=1, `res_type`=10.
- Both sources valid on the first cycle after reset → source 0 is served first, then source 1. `src_ready` is never high for both, and the two records appear in `chk_char` un-interleaved.
- Source 0 sends `^1@123:$1<=0#` → `res_type`=00, `res_overflow`=0.
- With DEPTH=16, a 30-byte valid record → `res_overflow`=1, `res_type`=00, and `chk_char` stays 8'h00 throughout.
- `reset` is asserted during PLAY → all outputs return to their reset values immediately; a following valid record from source 0 reports 01.
